gpio_cmd_decoder: RTL and testbench
===================================

# gpio_cmd_decoder

Receives host register transactions on the PS GPIO bus, decodes them into single-cycle write strobes toward the configuration register file, and returns readback data on the GPIO output bus. It is the fabric-side end of the host GPIO command protocol and sits between the AXI GPIO output and the register file in the RF clock domain. A strobe on the GPIO write-clock bit marks each host transaction. Each completed transaction toggles an acknowledge bit so the host can poll for completion.

## Interface
- `FIFO_DEPTH_LOG2`, 2: depth of the write queue (4 entries).
- `RD_TIMEOUT`, 255: number of cycles to wait for `rd_valid` before flagging a read error.
- `clk` in 1: fabric clock.
- `rst` in 1: asynchronous, active-low reset.
- `gpio_in` in 32: host bus, asynchronous to `clk`.
  - Bit 24 is the write clock.
  - Bits 23:16 are data.
  - Bits 15:0 are the address.
  - Bit 25 is read-not-write.
- `gpio_out` out 32: response bus.
  - Bits 7:0 are readback data.
  - Bit 24 is the ack toggle.
  - Bit 25 is the read-timeout error.
  - Bit 26 is the sticky overflow flag.
  - All other bits are 0.
- `wr_valid` out 1, `wr_ready` in 1: write handshake toward the register file.
- `wr_addr` out 16, `wr_data` out 8: write payload, held stable while `wr_valid` is high and `wr_ready` is low.
- `rd_req` out 1: one-cycle read request.
- `rd_addr` out 16: read address, held stable until the response arrives or the read times out.
- `rd_valid` in 1, `rd_data` in 8: read response.
- `busy` out 1: high while the FIFO is non-empty or a read is outstanding.

## Operation
- **Synchronising `gpio_in`.**
  - Bit 24 passes through a 2-flop synchronizer, followed by a third flop used for edge detection.
  - The remaining bits pass through a 2-flop register stage.
  - The host guarantees that address, data and bit 25 are stable at least 4 `clk` cycles before bit 24 rises. Addr/data/rw are therefore sampled from the registered stage on the cycle the synchronized rising edge is detected.
- **Write path (bit 25 = 0).**
  - On a rising edge, `{addr, data}` is pushed into the write FIFO.
  - The FIFO head drives `wr_addr`/`wr_data`, with `wr_valid` = not empty.
  - An entry pops when `wr_valid && wr_ready`.
  - The ack toggles on the push, not on the pop.
- **Push to a full FIFO.** The entry is dropped, sticky bit 26 is set, and the ack still toggles. Bit 26 is cleared only by reset.
- **Simultaneous push and pop on a full FIFO.** Both happen and no overflow is flagged.
- **Read path (bit 25 = 1).** The read state machine has two states.
  - **IDLE.** On a rising edge with bit 25 = 1:
    - Assert `rd_req` for 1 cycle.
    - Latch `rd_addr` and clear the timeout counter.
    - Move to RD_WAIT.
  - **RD_WAIT, `rd_valid` = 1.** Load `gpio_out[7:0]` with `rd_data`, clear bit 25, toggle the ack, and return to IDLE.
  - **RD_WAIT, counter reaches `RD_TIMEOUT`.** Load `gpio_out[7:0]` with 0xFF, set bit 25, toggle the ack, and return to IDLE.
  - **Edge arriving in RD_WAIT.** The transaction is ignored and there is no ack (protocol violation). The host must wait for the ack before issuing the next command.
- **Reads bypass the FIFO.** The host orders them by waiting for the ack and for `busy` to clear.
- **Falling edges** of bit 24 are ignored.

## Timing
- **Reset values:**
  - `gpio_out` = 0.
  - `wr_valid` = 0 and `rd_req` = 0.
  - `wr_addr` = 0, `wr_data` = 0 and `rd_addr` = 0.
  - `busy` = 0.
  - FIFO empty, read state machine in IDLE.
- **Latency** from `gpio_in[24]` rising:
  - 3 `clk` cycles to edge detect.
  - `wr_valid` rises in cycle 4 if the FIFO was empty.
  - The ack toggles in cycle 4 for writes.
- **Read latency.** `rd_req` is asserted in cycle 4. `gpio_out` updates on the cycle after `rd_valid` is sampled high.
- **`gpio_out` stability.** All bits change in the same cycle, so the host sees a coherent word once the ack has toggled.
- **Reset asserted mid-transaction.** The FIFO contents and any outstanding read are discarded. A `rd_valid` arriving after reset is ignored.
- **`rd_valid` while in IDLE.** Ignored.

## Structure
- **Shared package.** Add to the shared config package:
  - `gpio_rw_bit = 25`.
  - `gpio_ack_bit = 24`.
  - `gpio_err_bit = 25`.
  - `gpio_ovf_bit = 26`.
  - The existing `gpio_w_clk_bit`, addr/data start/end and width constants are reused directly.
  - Ack position: `gpio_ack_bit` (24) on `gpio_out` matches `gpio_w_clk_bit` on `gpio_in`.
- **Sub-module.** One sub-module, `gpio_wr_fifo`: a synchronous FIFO of 24 bits × 2^`FIFO_DEPTH_LOG2` entries with full/empty flags. The synchronizer, edge detect and read state machine stay in the top module.

## Test plan
- **Single write.** Host sets addr 0x000C, data 0x5A, then raises bit 24.
  - `wr_valid` with `wr_addr` = 0x000C and `wr_data` = 0x5A appears 4 cycles later.
  - The ack toggles 0→1.
  - The entry pops on the first `wr_ready`.
- **Backpressure and overflow.** Hold `wr_ready` = 0 and issue 5 writes (data 1..5).
  - Writes 1–4 are queued; write 5 is dropped.
  - Bit 26 = 1 and the ack has toggled 5 times.
  - Releasing `wr_ready` delivers 1,2,3,4 in order.
- **Read.** Host issues a read of 0x0008 and the register file answers `rd_data` = 0xC3 after 10 cycles.
  - `rd_req` pulses once with `rd_addr` = 0x0008.
  - `gpio_out[7:0]` = 0xC3, bit 25 = 0, ack toggled.
- **Read timeout.** Issue a read and never assert `rd_valid`.
  - After 255 cycles `gpio_out[7:0]` = 0xFF, bit 25 = 1, ack toggled.
  - A subsequent successful read clears bit 25.
- **Edge cases.**
  - Hold bit 24 high for 100 cycles: exactly one write is produced.
  - A second edge issued during RD_WAIT produces no write and no ack.
- **Reset mid-operation.** Assert `rst` low with 3 FIFO entries queued and a read outstanding.
  - All outputs take their reset values.
  - A late `rd_valid` is ignored.
  - The next write works normally.

Source files
------------

// File: rtl/gpio_cmd_decoder_pkg.sv
// Shared constants and types for the host GPIO command protocol.
// Bit positions on gpio_in / gpio_out plus the decoded command and write-queue entry.
package gpio_cmd_decoder_pkg;

  localparam int gpio_w_clk_bit    = 24;
  localparam int gpio_addr_start   = 0;
  localparam int gpio_addr_end     = 15;
  localparam int gpio_data_start   = 16;
  localparam int gpio_data_end     = 23;
  localparam int gpio_addr_width   = 16;
  localparam int gpio_data_width   = 8;

  localparam int gpio_rw_bit       = 25;
  // Ack sits on gpio_out at the same position as the write clock on gpio_in.
  localparam int gpio_ack_bit      = 24;
  localparam int gpio_err_bit      = 25;
  localparam int gpio_ovf_bit      = 26;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic [gpio_addr_width-1:0] addr;
    logic [gpio_data_width-1:0] data;
  } wr_entry_t;

  typedef struct packed {
    logic      rw;
    wr_entry_t entry;
  } gpio_cmd_t;

endpackage

// File: rtl/gpio_cmd_decoder_if.sv
// Host GPIO bus plus register-file write/read handshakes.
// slave = decoder side, master = host/register-file side.
interface gpio_cmd_decoder_if;
  import gpio_cmd_decoder_pkg::*;

  logic [31:0]                gpio_in;
  logic [31:0]                gpio_out;
  logic                       wr_valid;
  logic                       wr_ready;
  logic [gpio_addr_width-1:0] wr_addr;
  logic [gpio_data_width-1:0] wr_data;
  logic                       rd_req;
  logic [gpio_addr_width-1:0] rd_addr;
  logic                       rd_valid;
  logic [gpio_data_width-1:0] rd_data;
  logic                       busy;

  modport slave (
    input  gpio_in, wr_ready, rd_valid, rd_data,
    output gpio_out, wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy
  );

  modport master (
    output gpio_in, wr_ready, rd_valid, rd_data,
    input  gpio_out, wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy
  );

endinterface

// File: rtl/gpio_wr_fifo.sv
// Small synchronous FIFO for queued register writes; head is shown combinationally.
// Storage is reset so the head reads zero after reset.
module gpio_wr_fifo #(
  parameter int WIDTH      = 24,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH_LOG2:0]         wptr, rptr;
  logic                        do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                   (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[DEPTH_LOG2-1:0]] <= push_data;
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) rptr <= rptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/gpio_cmd_decoder.sv
// Decodes host GPIO transactions into register-file write strobes and reads,
// returning readback data, an ack toggle and error/overflow flags on gpio_out.
module gpio_cmd_decoder
  import gpio_cmd_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int RD_TIMEOUT      = 255
) (
  input logic               clk,
  input logic               rst,
  gpio_cmd_decoder_if.slave bus
);

  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = 1;

  logic [2:0]      wclk_sync;
  gpio_cmd_t [1:0] cmd_q;
  gpio_cmd_t       cmd_in, cmd;
  logic            rise, wr_cmd, rd_cmd;
  logic            unused_gpio;

  logic            fifo_full, fifo_empty, fifo_pop;
  wr_entry_t       fifo_head;

  rd_state_e                  state_q;
  logic                       rd_req_q;
  logic [gpio_addr_width-1:0] rd_addr_q;
  logic [TMO_W-1:0]           tmo_cnt;
  logic [gpio_data_width-1:0] rdata_q;
  logic                       ack_q, err_q, ovf_q;
  logic [31:0]                gpio_out_w;

  assign unused_gpio = ^bus.gpio_in[31:gpio_ovf_bit];

  assign cmd_in.rw         = bus.gpio_in[gpio_rw_bit];
  assign cmd_in.entry.addr = bus.gpio_in[gpio_addr_end:gpio_addr_start];
  assign cmd_in.entry.data = bus.gpio_in[gpio_data_end:gpio_data_start];

  // wclk_sync[1:0] is the synchronizer, wclk_sync[2] the edge-detect history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wclk_sync <= '0;
      cmd_q     <= '0;
    end else begin
      wclk_sync <= {wclk_sync[1:0], bus.gpio_in[gpio_w_clk_bit]};
      cmd_q     <= {cmd_q[0], cmd_in};
    end
  end

  assign rise = wclk_sync[1] & ~wclk_sync[2];
  assign cmd  = cmd_q[1];
  // Any edge seen while a read is outstanding is a protocol violation and dropped.
  assign wr_cmd = rise & ~cmd.rw & (state_q == RD_IDLE);
  assign rd_cmd = rise &  cmd.rw & (state_q == RD_IDLE);

  assign fifo_pop = ~fifo_empty & bus.wr_ready;

  gpio_wr_fifo #(
    .WIDTH      ($bits(wr_entry_t)),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_cmd),
    .push_data (cmd.entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RD_IDLE;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      tmo_cnt   <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rd_req_q <= 1'b0;
      if (wr_cmd) begin
        ack_q <= ~ack_q;
        if (fifo_full && !fifo_pop) ovf_q <= 1'b1;
      end
      case (state_q)
        RD_IDLE: begin
          if (rd_cmd) begin
            rd_req_q  <= 1'b1;
            rd_addr_q <= cmd.entry.addr;
            tmo_cnt   <= '0;
            state_q   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.rd_valid) begin
            rdata_q <= bus.rd_data;
            err_q   <= 1'b0;
            ack_q   <= ~ack_q;
            state_q <= RD_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            rdata_q <= '1;
            err_q   <= 1'b1;
            ack_q   <= ~ack_q;
            state_q <= RD_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  always_comb begin
    gpio_out_w = '0;
    gpio_out_w[gpio_data_width-1:0] = rdata_q;
    gpio_out_w[gpio_ack_bit]        = ack_q;
    gpio_out_w[gpio_err_bit]        = err_q;
    gpio_out_w[gpio_ovf_bit]        = ovf_q;
  end

  assign bus.gpio_out = gpio_out_w;
  assign bus.wr_valid = ~fifo_empty;
  assign bus.wr_addr  = fifo_head.addr;
  assign bus.wr_data  = fifo_head.data;
  assign bus.rd_req   = rd_req_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.busy     = ~fifo_empty | (state_q == RD_WAIT);

endmodule

// File: tb/tb_gpio_cmd_decoder.sv
// Directed plus randomized bench for gpio_cmd_decoder against a transaction-level model.
module tb_gpio_cmd_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_cmd_decoder_if bus();

  gpio_cmd_decoder #(.FIFO_DEPTH_LOG2(2), .RD_TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 0;  // 0: ready low, 1: ready high, 2: random

  // Model: host-visible response word and the queue of writes not yet delivered.
  logic [23:0] exp_q[$];
  logic        m_ack = 1'b0, m_ovf = 1'b0, m_err = 1'b0;
  logic [7:0]  m_rdata = 8'h00;

  function automatic logic [31:0] m_out();
    return {5'b0, m_ovf, m_err, m_ack, 16'h0000, m_rdata};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Set up a command with the write clock low, hold it stable, then raise the clock.
  task automatic raise(input bit rw, input logic [15:0] a, input logic [7:0] d);
    bus.gpio_in = 32'h0;
    bus.gpio_in[25] = rw;
    bus.gpio_in[23:16] = d;
    bus.gpio_in[15:0] = a;
    cyc(5);
    bus.gpio_in[24] = 1'b1;
  endtask

  task automatic wait_ack(input string tag);
    for (int i = 0; i < 400 && bus.gpio_out[24] !== m_ack; i++) cyc();
    check(tag, bus.gpio_out, m_out());
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && bus.busy !== 1'b0; i++) cyc();
    check(tag, {31'b0, bus.busy}, 32'h0);
  endtask

  task automatic write_cmd(input logic [15:0] a, input logic [7:0] d, input string tag);
    if (exp_q.size() < 4) exp_q.push_back({a, d});
    else m_ovf = 1'b1;
    m_ack = ~m_ack;
    raise(1'b0, a, d);
    wait_ack(tag);
  endtask

  // Read with exact rd_req timing; optional response after lat idle cycles.
  task automatic read_cmd(input logic [15:0] a, input logic [7:0] d, input int lat,
                          input bit respond, input string tag);
    raise(1'b1, a, 8'h00);
    cyc(2);
    check({tag, "_req_early"}, {31'b0, bus.rd_req}, 32'h0);
    cyc();
    check({tag, "_req"}, {15'b0, bus.rd_req, bus.rd_addr}, {15'b0, 1'b1, a});
    cyc();
    check({tag, "_req_pulse"}, {30'b0, bus.rd_req, bus.busy}, 32'h1);
    if (respond) begin
      cyc(lat);
      bus.rd_data  = d;
      bus.rd_valid = 1'b1;
      cyc();
      bus.rd_valid = 1'b0;
      m_rdata = d;
      m_err   = 1'b0;
      m_ack   = ~m_ack;
      check({tag, "_resp"}, bus.gpio_out, m_out());
    end
  endtask

  // wr_ready driver
  initial begin
    bus.wr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.wr_ready = 1'b0;
        1:       bus.wr_ready = 1'b1;
        default: bus.wr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard for delivered writes; the handshake completes on the coming posedge.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 24'hxxxxxx;
        check("wr_beat", {8'h00, bus.wr_addr, bus.wr_data}, {8'h00, e});
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus.gpio_in  = 32'h0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = 8'h00;
    cyc(3);
    check("rst_gpio_out", bus.gpio_out, 32'h0);
    check("rst_wr", {7'b0, bus.wr_valid, bus.wr_addr, bus.wr_data}, 32'h0);
    check("rst_rd", {14'b0, bus.rd_req, bus.busy, bus.rd_addr}, 32'h0);
    rst = 1'b1;
    cyc(2);

    // Single write with exact latency, then pop on first ready
    rdy_mode = 0;
    exp_q.push_back({16'h000C, 8'h5A});
    m_ack = ~m_ack;
    raise(1'b0, 16'h000C, 8'h5A);
    cyc(2);
    check("wr_early", {31'b0, bus.wr_valid}, 32'h0);
    cyc();
    check("wr_first", {7'b0, bus.wr_valid, bus.wr_addr, bus.wr_data}, {7'b0, 1'b1, 16'h000C, 8'h5A});
    check("wr_ack", bus.gpio_out, m_out());
    bus.gpio_in[24] = 1'b0;
    cyc(3);
    check("wr_hold", {7'b0, bus.wr_valid, bus.wr_addr, bus.wr_data}, {7'b0, 1'b1, 16'h000C, 8'h5A});
    rdy_mode = 1;
    cyc(3);
    check("wr_popped", {30'b0, bus.wr_valid, bus.busy}, 32'h0);

    // Backpressure: five writes into a four-deep queue
    rdy_mode = 0;
    for (int i = 1; i <= 5; i++) write_cmd(16'h0100 + 16'(i), 8'(i), "ovf_wr");
    check("ovf_head", {7'b0, bus.wr_valid, bus.wr_addr, bus.wr_data}, {7'b0, 1'b1, 16'h0101, 8'h01});
    check("ovf_flag", bus.gpio_out, m_out());
    rdy_mode = 1;
    wait_idle("ovf_drain");
    check("ovf_q_empty", exp_q.size(), 32'h0);

    // Write clock held high for 100 cycles gives exactly one write
    exp_q.push_back({16'h0033, 8'h77});
    m_ack = ~m_ack;
    raise(1'b0, 16'h0033, 8'h77);
    cyc(100);
    check("hold_ack", bus.gpio_out, m_out());
    check("hold_one", exp_q.size(), 32'h0);
    bus.gpio_in[24] = 1'b0;
    cyc(5);
    check("hold_fall", bus.gpio_out, m_out());

    // Read answered after 10 cycles
    read_cmd(16'h0008, 8'hC3, 10, 1'b1, "rd");
    cyc(2);
    check("rd_idle", {31'b0, bus.busy}, 32'h0);

    // rd_valid while idle is ignored
    bus.rd_data  = 8'h5E;
    bus.rd_valid = 1'b1;
    cyc();
    bus.rd_valid = 1'b0;
    cyc();
    check("rd_valid_idle", bus.gpio_out, m_out());

    // Read timeout
    read_cmd(16'h0010, 8'h00, 0, 1'b0, "tmo");
    cyc(253);
    check("tmo_early", bus.gpio_out, m_out());
    cyc();
    m_rdata = 8'hFF;
    m_err   = 1'b1;
    m_ack   = ~m_ack;
    check("tmo", bus.gpio_out, m_out());
    read_cmd(16'h0011, 8'h24, 3, 1'b1, "rd_clr_err");

    // Second edge during RD_WAIT is dropped
    read_cmd(16'h0020, 8'h00, 0, 1'b0, "rdw");
    raise(1'b0, 16'h0055, 8'h99);
    cyc(6);
    check("rdw_no_wr", {30'b0, bus.wr_valid, bus.busy}, 32'h1);
    check("rdw_no_ack", bus.gpio_out, m_out());
    bus.rd_data  = 8'h3C;
    bus.rd_valid = 1'b1;
    cyc();
    bus.rd_valid = 1'b0;
    m_rdata = 8'h3C;
    m_err   = 1'b0;
    m_ack   = ~m_ack;
    check("rdw_resp", bus.gpio_out, m_out());
    cyc(3);
    check("rdw_no_wr_after", {31'b0, bus.wr_valid}, 32'h0);

    // Randomized transactions
    rdy_mode = 2;
    for (int n = 0; n < 16; n++) begin
      logic [15:0] a;
      logic [7:0]  d;
      a = 16'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        write_cmd(a, d, "rnd_wr");
        wait_idle("rnd_wr_idle");
        check("rnd_wr_drain", exp_q.size(), 32'h0);
      end else begin
        read_cmd(a, d, int'($urandom_range(0, 30)), 1'b1, "rnd_rd");
      end
    end

    // Reset with queued writes and an outstanding read
    rdy_mode = 0;
    cyc(2);
    for (int i = 0; i < 3; i++) write_cmd(16'h0200 + 16'(i), 8'hA0 + 8'(i), "rst_q_wr");
    read_cmd(16'h0044, 8'h00, 0, 1'b0, "rst_rd");
    bus.gpio_in = 32'h0;
    rst = 1'b0;
    exp_q.delete();
    m_ack = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_rdata = 8'h00;
    cyc();
    check("mid_rst_gpio_out", bus.gpio_out, m_out());
    check("mid_rst_wr", {7'b0, bus.wr_valid, bus.wr_addr, bus.wr_data}, 32'h0);
    check("mid_rst_rd", {14'b0, bus.rd_req, bus.busy, bus.rd_addr}, 32'h0);
    rst = 1'b1;
    cyc();
    bus.rd_data  = 8'hEE;
    bus.rd_valid = 1'b1;
    cyc();
    bus.rd_valid = 1'b0;
    cyc();
    check("late_rd_valid", {bus.gpio_out[31:1], bus.busy}, {m_out()[31:1], 1'b0});
    rdy_mode = 1;
    write_cmd(16'h0077, 8'hAB, "post_rst_wr");
    wait_idle("post_rst_idle");
    check("post_rst_drain", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
